uart_fifo_gen2: RTL and testbench
=================================

# uart_fifo_gen2

Parametrised receive-side FIFO for the UART core, replacing the fixed 16×8 shift-register FIFO with a circular buffer of configurable width and depth. It sits between the RX deserialiser (push side) and the host register interface (pop side). It exposes an occupancy count, a programmable fill-level trigger, overrun/underrun pulses and an optional 16550-style character timeout.

## Interface
- `DATA_W`, default 8: data word width in bits (the parity/error sideband is carried by widening this value).
- `ADDR_W`, default 4: pointer width; `DEPTH = 2**ADDR_W` entries.
- `TIMEOUT_CYCLES`, default 64: idle cycles before `rx_timeout` asserts; range 2..65535; used only with `UART_FIFO_TIMEOUT_EN`.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `en` in 1: FIFO enable; low means synchronous flush and hold.
- `push_in` in 1: write request from the deserialiser.
- `pop_in` in 1: read request from the host.
- `din` in `DATA_W`: write data.
- `threshold` in `ADDR_W+1`: trigger level, 0..DEPTH; 0 disables the trigger.
- `dout` out `DATA_W`: head word (show-ahead); 0 when empty.
- `count` out `ADDR_W+1`: occupancy, 0..DEPTH.
- `empty` out 1: `count == 0`.
- `full` out 1: `count == DEPTH`.
- `overrun` out 1: one-cycle pulse on a rejected push.
- `underrun` out 1: one-cycle pulse on a rejected pop.
- `thre_trigger` out 1: `count >= threshold`, with `threshold != 0`.
- `rx_timeout` out 1: character timeout flag.

## Operation
- Storage: `DEPTH`×`DATA_W` array with no reset. Write pointer `wptr`, read pointer `rptr` (each `ADDR_W` bits, natural wrap at DEPTH−1→0), and a `count` register.
- Pop accepted: `pop = pop_in & en & ~empty`.
- Push accepted: `push = push_in & en & (~full | pop)`. When full, a simultaneous push and pop both succeed.
- Push: `mem[wptr] <= din`, `wptr++`. Pop: `rptr++`. Count changes by +1 on push only, −1 on pop only, and is unchanged when both or neither occur.
- `dout = empty ? 0 : mem[rptr]`, driven combinationally from registered state.
- `overrun` register is set to `push_in & en & ~push` and `underrun` to `pop_in & en & empty`. Each is high for exactly one cycle per offending request and never sticky.
- `thre_trigger` register is loaded every cycle with `(count_next >= threshold) && threshold != 0`.
- `en=0`: on the next edge `wptr`, `rptr` and `count` clear to 0 and `thre_trigger`, `overrun`, `underrun` and `rx_timeout` clear. push_in and pop_in are ignored while en is low.
- Reset: `count=0`, `empty=1`, `full=0`, `dout=0`, `overrun=0`, `underrun=0`, `thre_trigger=0`, `rx_timeout=0`, and all pointers 0.

## Timing
- Push at edge N: `count`, `empty` and `full` update at N, and the word is visible on `dout` after N if the FIFO was empty.
- Pop at edge N: the next word appears on `dout` after N. There is zero-cycle read latency for the head word.
- `overrun`, `underrun` and `thre_trigger` are registered. They reflect the request or level of the same edge and are valid in the cycle after it.
- Wrap: pointers roll over silently. `count` is the sole source for the full/empty flags, so there is no pointer-compare ambiguity.
- Reset mid-operation clears the state immediately (asynchronously). Memory contents are don't-care because `dout` is masked by `empty`.

## Configuration
- Macro `UART_FIFO_TIMEOUT_EN`.
  - Defined: an idle counter of width `$clog2(TIMEOUT_CYCLES+1)` clears on any accepted push or pop, on `en=0`, or when `empty=1`.
    - Otherwise it increments, saturating at `TIMEOUT_CYCLES`.
    - `rx_timeout` goes high on the edge where the counter reaches `TIMEOUT_CYCLES` and stays high until the next push, pop, flush or reset.
  - Undefined: `rx_timeout` is tied to 0 and no counter is instantiated.

## Test plan
- Reset, then 16 pushes of 0x01..0x10 (defaults) → `count` 1..16, `full=1` after the 16th, `dout=0x01`; a 17th push gives a one-cycle `overrun`, with `count=16` and the contents unchanged.
- Pop 16 times from full → `dout` sequence 0x01..0x10, then `empty=1` and `dout=0`; a 17th pop gives a one-cycle `underrun`.
- Wrap: push 10, pop 10, push 12 (0xA0..0xAB) → `count=12`, and the pops return 0xA0..0xAB in order across the pointer wrap.
- Simultaneous push and pop when full (push 0x55) → `count` stays 16, `full` stays 1, no `overrun`, and 0x55 is the last word out. Simultaneous push and pop when empty → push only, `count=1`, `underrun=1`.
- `threshold=4`: 4th push → `thre_trigger=1` the next cycle; a pop to count 3 → 0. `threshold=0` → never asserts. `en=0` with count 7 → one edge later `count=0` and `empty=1`.
- `UART_FIFO_TIMEOUT_EN`, `TIMEOUT_CYCLES=64`: push 1 word then idle → `rx_timeout=1` exactly 64 cycles after the push; a pop clears it; an empty FIFO never times out.

Source files
------------

// File: rtl/uart_fifo_gen2_if.sv
// uart_fifo_gen2_if: handshake and status bundle between the UART RX
// deserialiser/host side (master) and the receive FIFO (slave).
interface uart_fifo_gen2_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              en;
  logic              push_in;
  logic              pop_in;
  logic [DATA_W-1:0] din;
  logic [ADDR_W:0]   threshold;
  logic [DATA_W-1:0] dout;
  logic [ADDR_W:0]   count;
  logic              empty;
  logic              full;
  logic              overrun;
  logic              underrun;
  logic              thre_trigger;
  logic              rx_timeout;

  modport master (
    output en, push_in, pop_in, din, threshold,
    input  dout, count, empty, full, overrun, underrun, thre_trigger, rx_timeout
  );

  modport slave (
    input  en, push_in, pop_in, din, threshold,
    output dout, count, empty, full, overrun, underrun, thre_trigger, rx_timeout
  );
endinterface

// File: rtl/uart_fifo_gen2.sv
// uart_fifo_gen2: circular-buffer receive FIFO for the UART core.
// Show-ahead head word, occupancy count, fill-level trigger and
// overrun/underrun pulses. Optional character timeout is compiled in
// with macro UART_FIFO_TIMEOUT_EN.
module uart_fifo_gen2 #(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst,
  uart_fifo_gen2_if.slave  f
);
  localparam int              DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overrun_q, overrun_d;
  logic              underrun_q, underrun_d;
  logic              thre_q, thre_d;
  logic              empty, full, push, pop;

  // count alone decides full/empty, so pointer equality is never ambiguous
  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);
  assign pop   = f.pop_in & f.en & ~empty;
  assign push  = f.push_in & f.en & (~full | pop);

  // next-state for pointers, occupancy and the registered status pulses
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    overrun_d  = 1'b0;
    underrun_d = 1'b0;
    thre_d     = 1'b0;
    if (!f.en) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop)  rptr_d = rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      overrun_d  = f.push_in & ~push;
      underrun_d = f.pop_in & empty;
      thre_d     = (count_d >= f.threshold) && (f.threshold != '0);
    end
  end

  // control state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
      thre_q     <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
      thre_q     <= thre_d;
    end
  end

  // storage has no reset; stale words are hidden because dout is masked by empty
  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= f.din;
  end

  assign f.dout         = empty ? '0 : mem[rptr_q];
  assign f.count        = count_q;
  assign f.empty        = empty;
  assign f.full         = full;
  assign f.overrun      = overrun_q;
  assign f.underrun     = underrun_q;
  assign f.thre_trigger = thre_q;

`ifdef UART_FIFO_TIMEOUT_EN
  localparam int            TO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

  logic [TO_W-1:0] idle_q, idle_d;
  logic            rx_timeout_q, rx_timeout_d;

  // idle counter: restarts on any traffic, flush or empty FIFO, saturates at the limit
  always_comb begin
    idle_d = idle_q;
    if (!f.en || push || pop || empty) begin
      idle_d = '0;
    end else if (idle_q != TO_MAX) begin
      idle_d = idle_q + 1'b1;
    end
    rx_timeout_d = (idle_d == TO_MAX);
  end

  // timeout state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_q       <= '0;
      rx_timeout_q <= 1'b0;
    end else begin
      idle_q       <= idle_d;
      rx_timeout_q <= rx_timeout_d;
    end
  end

  assign f.rx_timeout = rx_timeout_q;
`else
  // timeout compiled out; TIMEOUT_CYCLES is never 0, so this is a constant low
  assign f.rx_timeout = (TIMEOUT_CYCLES == 0);
`endif
endmodule

// File: tb/tb_uart_fifo_gen2.sv
// tb_uart_fifo_gen2: directed self-checking bench for uart_fifo_gen2.
module tb_uart_fifo_gen2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  uart_fifo_gen2_if #(.DATA_W(8), .ADDR_W(4)) bus ();

  uart_fifo_gen2 #(.DATA_W(8), .ADDR_W(4), .TIMEOUT_CYCLES(64)) dut (
    .clk (clk),
    .rst (rst),
    .f   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, need finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.en = 1'b1; bus.push_in = 1'b0; bus.pop_in = 1'b0;
    bus.din = '0; bus.threshold = '0;
    tick(); tick();
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d need 0", bus.count); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b need 1", bus.empty); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got %b need 0", bus.full); end
    checks++; if (bus.dout !== 8'h00) begin errors++; $display("FAIL reset_dout got %h need 00", bus.dout); end
    checks++; if ({bus.overrun, bus.underrun, bus.thre_trigger, bus.rx_timeout} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b need 0000",
                         {bus.overrun, bus.underrun, bus.thre_trigger, bus.rx_timeout});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fill_overrun();
    bus.push_in = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      bus.din = 8'(i);
      tick();
      checks++; if (bus.count !== 5'(i)) begin errors++; $display("FAIL fill_count[%0d] got %0d need %0d", i, bus.count, i); end
      checks++; if (bus.dout !== 8'h01) begin errors++; $display("FAIL fill_dout[%0d] got %h need 01", i, bus.dout); end
      checks++; if (bus.full !== (i == 16)) begin errors++; $display("FAIL fill_full[%0d] got %b need %b", i, bus.full, (i == 16)); end
    end
    bus.din = 8'h99;
    tick();
    bus.push_in = 1'b0;
    checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL overrun_pulse got %b need 1", bus.overrun); end
    checks++; if (bus.count !== 5'd16) begin errors++; $display("FAIL overrun_count got %0d need 16", bus.count); end
    tick();
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL overrun_clear got %b need 0", bus.overrun); end
    checks++; if (bus.dout !== 8'h01) begin errors++; $display("FAIL overrun_dout got %h need 01", bus.dout); end
  endtask

  task automatic test_drain_underrun();
    bus.pop_in = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      checks++; if (bus.dout !== 8'(i)) begin errors++; $display("FAIL drain_dout[%0d] got %h need %h", i, bus.dout, 8'(i)); end
      tick();
    end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %b need 1", bus.empty); end
    checks++; if (bus.dout !== 8'h00) begin errors++; $display("FAIL drain_dout_zero got %h need 00", bus.dout); end
    checks++; if (bus.underrun !== 1'b0) begin errors++; $display("FAIL drain_no_underrun got %b need 0", bus.underrun); end
    tick();
    bus.pop_in = 1'b0;
    checks++; if (bus.underrun !== 1'b1) begin errors++; $display("FAIL underrun_pulse got %b need 1", bus.underrun); end
    tick();
    checks++; if (bus.underrun !== 1'b0) begin errors++; $display("FAIL underrun_clear got %b need 0", bus.underrun); end
  endtask

  task automatic test_wrap();
    bus.push_in = 1'b1;
    for (int i = 0; i < 10; i++) begin bus.din = 8'(8'h10 + i); tick(); end
    bus.push_in = 1'b0;
    bus.pop_in = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    bus.pop_in = 1'b0;
    bus.push_in = 1'b1;
    for (int i = 0; i < 12; i++) begin bus.din = 8'(8'hA0 + i); tick(); end
    bus.push_in = 1'b0;
    checks++; if (bus.count !== 5'd12) begin errors++; $display("FAIL wrap_count got %0d need 12", bus.count); end
    bus.pop_in = 1'b1;
    for (int i = 0; i < 12; i++) begin
      checks++; if (bus.dout !== 8'(8'hA0 + i)) begin errors++; $display("FAIL wrap_dout[%0d] got %h need %h", i, bus.dout, 8'(8'hA0 + i)); end
      tick();
    end
    bus.pop_in = 1'b0;
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL wrap_empty got %b need 1", bus.empty); end
  endtask

  task automatic test_simultaneous();
    bus.push_in = 1'b1;
    for (int i = 0; i < 16; i++) begin bus.din = 8'(8'h30 + i); tick(); end
    bus.pop_in = 1'b1;
    bus.din = 8'h55;
    tick();
    bus.push_in = 1'b0; bus.pop_in = 1'b0;
    checks++; if (bus.count !== 5'd16) begin errors++; $display("FAIL simfull_count got %0d need 16", bus.count); end
    checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL simfull_full got %b need 1", bus.full); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL simfull_overrun got %b need 0", bus.overrun); end
    bus.pop_in = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      logic [7:0] exp;
      exp = (i == 16) ? 8'h55 : 8'(8'h30 + i);
      checks++; if (bus.dout !== exp) begin errors++; $display("FAIL simfull_dout[%0d] got %h need %h", i, bus.dout, exp); end
      tick();
    end
    bus.push_in = 1'b1;
    bus.din = 8'h77;
    tick();
    bus.push_in = 1'b0; bus.pop_in = 1'b0;
    checks++; if (bus.count !== 5'd1) begin errors++; $display("FAIL simempty_count got %0d need 1", bus.count); end
    checks++; if (bus.underrun !== 1'b1) begin errors++; $display("FAIL simempty_underrun got %b need 1", bus.underrun); end
    checks++; if (bus.dout !== 8'h77) begin errors++; $display("FAIL simempty_dout got %h need 77", bus.dout); end
    bus.pop_in = 1'b1;
    tick();
    bus.pop_in = 1'b0;
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL simempty_drain got %b need 1", bus.empty); end
  endtask

  task automatic test_threshold_flush();
    bus.threshold = 5'd4;
    bus.push_in = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus.din = 8'(8'h40 + i);
      tick();
      checks++; if (bus.thre_trigger !== (i == 4)) begin errors++; $display("FAIL thre_push[%0d] got %b need %b", i, bus.thre_trigger, (i == 4)); end
    end
    bus.push_in = 1'b0;
    bus.pop_in = 1'b1;
    tick();
    bus.pop_in = 1'b0;
    checks++; if (bus.thre_trigger !== 1'b0) begin errors++; $display("FAIL thre_pop_to3 got %b need 0", bus.thre_trigger); end
    bus.push_in = 1'b1;
    for (int i = 0; i < 4; i++) begin bus.din = 8'(8'h50 + i); tick(); end
    bus.push_in = 1'b0;
    checks++; if (bus.thre_trigger !== 1'b1) begin errors++; $display("FAIL thre_count7 got %b need 1", bus.thre_trigger); end
    bus.threshold = 5'd0;
    tick();
    checks++; if (bus.thre_trigger !== 1'b0) begin errors++; $display("FAIL thre_zero got %b need 0", bus.thre_trigger); end
    checks++; if (bus.count !== 5'd7) begin errors++; $display("FAIL preflush_count got %0d need 7", bus.count); end
    bus.en = 1'b0;
    bus.push_in = 1'b1;
    tick();
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL flush_count got %0d need 0", bus.count); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL flush_empty got %b need 1", bus.empty); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL flush_overrun got %b need 0", bus.overrun); end
    bus.push_in = 1'b0;
    bus.en = 1'b1;
    tick();
  endtask

  task automatic test_async_reset();
    bus.push_in = 1'b1;
    for (int i = 0; i < 3; i++) begin bus.din = 8'(8'hC0 + i); tick(); end
    bus.push_in = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL arst_count got %0d need 0", bus.count); end
    checks++; if (bus.dout !== 8'h00) begin errors++; $display("FAIL arst_dout got %h need 00", bus.dout); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 70; i++) tick();
    checks++; if (bus.rx_timeout !== 1'b0) begin errors++; $display("FAIL to_empty got %b need 0", bus.rx_timeout); end
    bus.push_in = 1'b1;
    bus.din = 8'hE1;
    tick();
    bus.push_in = 1'b0;
`ifdef UART_FIFO_TIMEOUT_EN
    for (int i = 0; i < 63; i++) tick();
    checks++; if (bus.rx_timeout !== 1'b0) begin errors++; $display("FAIL to_early got %b need 0", bus.rx_timeout); end
    tick();
    checks++; if (bus.rx_timeout !== 1'b1) begin errors++; $display("FAIL to_assert got %b need 1", bus.rx_timeout); end
    tick();
    checks++; if (bus.rx_timeout !== 1'b1) begin errors++; $display("FAIL to_hold got %b need 1", bus.rx_timeout); end
`else
    for (int i = 0; i < 70; i++) tick();
    checks++; if (bus.rx_timeout !== 1'b0) begin errors++; $display("FAIL to_disabled got %b need 0", bus.rx_timeout); end
`endif
    bus.pop_in = 1'b1;
    tick();
    bus.pop_in = 1'b0;
    checks++; if (bus.rx_timeout !== 1'b0) begin errors++; $display("FAIL to_clear got %b need 0", bus.rx_timeout); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL to_empty_after got %b need 1", bus.empty); end
  endtask

  initial begin
    test_reset();
    test_fill_overrun();
    test_drain_underrun();
    test_wrap();
    test_simultaneous();
    test_threshold_flush();
    test_async_reset();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
